// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/resulton handshake.
// Optional SEQ_DIVIDER_DIVZERO_EN adds a divzero output and a one-cycle shortcut for b == 0.
module seq_divider #(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  resulton
`ifdef SEQ_DIVIDER_DIVZERO_EN
  ,
  output logic                  divzero
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY
`ifdef SEQ_DIVIDER_DIVZERO_EN
    ,
    DZERO
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic                   load;
  logic [DIVIDEND_W-1:0]  dvd_sh;
  logic [DIVISOR_W-1:0]   dvs;
  logic [DIVISOR_W:0]     prem;
  logic [CNT_W-1:0]       cnt;

  logic [DIVISOR_W:0]     shifted;
  logic [DIVISOR_W+1:0]   diff;
  logic                   qbit;
  logic [DIVISOR_W:0]     prem_nxt;
  logic [DIVIDEND_W-1:0]  q_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef SEQ_DIVIDER_DIVZERO_EN
          if (b == '0) state_nxt = DZERO;
          else         state_nxt = BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_nxt = IDLE;
      end
`ifdef SEQ_DIVIDER_DIVZERO_EN
      DZERO: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // The quotient bits fill the dividend shift register from the bottom as its MSBs are consumed.
  always_comb begin
    shifted  = {prem[DIVISOR_W-1:0], dvd_sh[DIVIDEND_W-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs};
    qbit     = ~diff[DIVISOR_W+1];
    prem_nxt = qbit ? diff[DIVISOR_W:0] : shifted;
    q_nxt    = {dvd_sh[DIVIDEND_W-2:0], qbit};
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_sh    <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      resulton  <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
      divzero   <= 1'b0;
`endif
    end else begin
      resulton <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
      divzero  <= 1'b0;
`endif
      if (load) begin
        dvd_sh <= a;
        dvs    <= b;
        prem   <= '0;
        cnt    <= CNT_W'(DIVIDEND_W);
      end else if (state == BUSY) begin
        dvd_sh <= q_nxt;
        prem   <= prem_nxt;
        cnt    <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          quotient  <= q_nxt;
          remainder <= prem_nxt[DIVISOR_W-1:0];
          resulton  <= 1'b1;
        end
      end
`ifdef SEQ_DIVIDER_DIVZERO_EN
      else if (state == DZERO) begin
        quotient  <= '1;
        remainder <= dvd_sh[DIVISOR_W-1:0];
        resulton  <= 1'b1;
        divzero   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider; expected results come from a scoreboard queue.
// Builds with or without SEQ_DIVIDER_DIVZERO_EN.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] a;
  logic [4:0] b;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       busy;
  logic       resulton;
`ifdef SEQ_DIVIDER_DIVZERO_EN
  logic       divzero;
`endif

  seq_divider #(.DIVIDEND_W(10), .DIVISOR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .resulton  (resulton)
`ifdef SEQ_DIVIDER_DIVZERO_EN
    ,
    .divzero   (divzero)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0] av;
    logic [4:0] bv;
    logic [9:0] q;
    logic [4:0] r;
    int         lat;
    int         busy_n;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] av, input logic [4:0] bv);
    exp_t e;
    e.av = av;
    e.bv = bv;
    e.dz = 1'b0;
    e.lat = 10;
    e.busy_n = 10;
    if (bv == 5'd0) begin
      e.q = 10'h3ff;
      e.r = av[4:0];
`ifdef SEQ_DIVIDER_DIVZERO_EN
      e.lat = 1;
      e.busy_n = 0;
      e.dz = 1'b1;
`endif
    end else begin
      e.q = av / {5'd0, bv};
      e.r = 5'(av % {5'd0, bv});
    end
    sb.push_back(e);
  endtask

  // Called just after the accepting edge; sample k is the negedge after edge N+k.
  task automatic collect(input int k0, input int b0);
    int   lat;
    int   bcnt;
    exp_t e;
    lat  = -1;
    bcnt = b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (resulton === 1'b1) begin
        lat = k0 + k;
        break;
      end
      bcnt += (busy === 1'b1) ? 1 : 0;
    end
    if (lat < 0) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("busy_cycles", bcnt, e.busy_n);
    check("quotient", {22'd0, quotient}, {22'd0, e.q});
    check("remainder", {27'd0, remainder}, {27'd0, e.r});
    check("busy_at_result", {31'd0, busy}, 32'd0);
`ifdef SEQ_DIVIDER_DIVZERO_EN
    check("divzero", {31'd0, divzero}, {31'd0, e.dz});
`endif
    if (e.bv != 5'd0) begin
      check("identity", 32'(quotient) * 32'(e.bv) + 32'(remainder), 32'(e.av));
      check("rem_lt_div", {31'd0, (remainder < e.bv)}, 32'd1);
    end
  endtask

  task automatic run_div(input logic [9:0] av, input logic [4:0] bv);
    logic [9:0] q_hold;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    push(av, bv);
    @(posedge clk);
    #1 start = 1'b0;
    a = ~av;
    b = ~bv;
    collect(0, 0);
    q_hold = quotient;
    @(negedge clk);
    check("pulse_one_cycle", {31'd0, resulton}, 32'd0);
    check("quotient_held", {22'd0, quotient}, {22'd0, q_hold});
  endtask

  initial begin
    int bc;
    int rcnt;
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_quotient", {22'd0, quotient}, 32'd0);
    check("rst_remainder", {27'd0, remainder}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resulton", {31'd0, resulton}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(10'd100, 5'd7);
    run_div(10'd1023, 5'd31);
    run_div(10'd1, 5'd1);
    run_div(10'd5, 5'd9);

    // start held high: second operation accepted in the resulton cycle
    push(10'd50, 5'd3);
    push(10'd50, 5'd3);
    @(negedge clk);
    a = 10'd50;
    b = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    bc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bc += (busy === 1'b1) ? 1 : 0;
      if (k == 2) begin
        a = 10'd999;
        b = 5'd1;
      end
      if (k == 5) begin
        a = 10'd50;
        b = 5'd3;
      end
    end
    collect(6, bc);
    @(posedge clk);
    #1 start = 1'b0;
    collect(0, 0);
    @(negedge clk);
    check("b2b_no_third", {31'd0, busy}, 32'd0);

    run_div(10'd37, 5'd0);

    // asynchronous reset mid-division
    @(negedge clk);
    a = 10'd200;
    b = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_quotient", {22'd0, quotient}, 32'd0);
    check("abort_remainder", {27'd0, remainder}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_resulton", {31'd0, resulton}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rcnt = 0;
    repeat (15) begin
      @(negedge clk);
      rcnt += (resulton === 1'b1) ? 1 : 0;
    end
    check("abort_no_pulse", rcnt, 32'd0);
    run_div(10'd200, 5'd9);

    run_div(10'd0, 5'd31);
    run_div(10'd1023, 5'd1);
    for (int i = 0; i < 300; i++) begin
      run_div(10'($urandom_range(0, 1023)), 5'($urandom_range(1, 31)));
    end

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
